// File: rtl/cache_fill_fsm_if.sv
// Bundle of cache-miss, main-memory and cache-array signals used by cache_fill_fsm.
// The master modport belongs to the fill controller and the slave modport to its environment.
interface cache_fill_fsm_if #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_WIDTH  = 16
);
   logic                           miss_detected;
   logic [ADDR_WIDTH-1:0]          miss_address;
   logic                           memory_data_valid;
   logic [15:0]                    memory_data;
   logic                           memory_enable;
   logic [ADDR_WIDTH-1:0]          memory_address;
   logic                           fsm_busy;
   logic                           write_data_array;
   logic [$clog2(BLOCK_WORDS)-1:0] word_offset;
   logic [15:0]                    fill_data;
   logic                           write_tag_array;
   logic                           fill_done;

   modport master (
      input  miss_detected, miss_address, memory_data_valid, memory_data,
      output memory_enable, memory_address, fsm_busy, write_data_array,
             word_offset, fill_data, write_tag_array, fill_done
   );

   modport slave (
      output miss_detected, miss_address, memory_data_valid, memory_data,
      input  memory_enable, memory_address, fsm_busy, write_data_array,
             word_offset, fill_data, write_tag_array, fill_done
   );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: streams one block from main memory into the cache arrays.
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN to issue and write the block in wrapped, critical-word-first order.
module cache_fill_fsm #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_WIDTH  = 16
) (
   input logic              clk,
   input logic              rst,
   cache_fill_fsm_if.master bus
);
   localparam int OW = $clog2(BLOCK_WORDS);
   localparam int CW = OW + 1;
   // Byte-address bits that lie inside one block; cleared to form the block base.
   localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << CW) - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] base_reg, base_next;
   logic [CW-1:0]         req_cnt_reg, req_cnt_next;
   logic [CW-1:0]         recv_cnt_reg, recv_cnt_next;
   logic [OW-1:0]         req_ord;
   logic [OW-1:0]         recv_ord;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   logic [OW-1:0] crit_reg, crit_next;

   assign req_ord  = crit_reg + req_cnt_reg[OW-1:0];
   assign recv_ord = crit_reg + recv_cnt_reg[OW-1:0];
`else
   assign req_ord  = req_cnt_reg[OW-1:0];
   assign recv_ord = recv_cnt_reg[OW-1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         base_reg     <= '0;
         req_cnt_reg  <= '0;
         recv_cnt_reg <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
         crit_reg     <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         base_reg     <= base_next;
         req_cnt_reg  <= req_cnt_next;
         recv_cnt_reg <= recv_cnt_next;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
         crit_reg     <= crit_next;
`endif
      end
   end

   always_comb begin
      state_next           = state_reg;
      base_next            = base_reg;
      req_cnt_next         = req_cnt_reg;
      recv_cnt_next        = recv_cnt_reg;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      crit_next            = crit_reg;
`endif
      bus.memory_enable    = 1'b0;
      bus.memory_address   = '0;
      bus.fsm_busy         = 1'b0;
      bus.write_data_array = 1'b0;
      bus.word_offset      = '0;
      bus.fill_data        = bus.memory_data;
      bus.write_tag_array  = 1'b0;
      bus.fill_done        = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.miss_detected) begin
               base_next     = bus.miss_address & ~OFFSET_MASK;
               req_cnt_next  = '0;
               recv_cnt_next = '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
               crit_next     = bus.miss_address[OW:1];
`endif
               state_next    = FILL;
            end
         end

         FILL: begin
            bus.fsm_busy = 1'b1;

            // Request side runs one word per cycle, independent of returns.
            if (req_cnt_reg < CW'(BLOCK_WORDS)) begin
               bus.memory_enable  = 1'b1;
               bus.memory_address = base_reg | {{(ADDR_WIDTH-OW-1){1'b0}}, req_ord, 1'b0};
               req_cnt_next       = req_cnt_reg + CW'(1);
            end

            if (bus.memory_data_valid && (recv_cnt_reg < CW'(BLOCK_WORDS))) begin
               bus.write_data_array = 1'b1;
               bus.word_offset      = recv_ord;
               recv_cnt_next        = recv_cnt_reg + CW'(1);
               // The last word also commits the tag; the block is resident after this edge.
               if (recv_cnt_reg == CW'(BLOCK_WORDS - 1)) begin
                  bus.write_tag_array = 1'b1;
                  bus.fill_done       = 1'b1;
                  state_next          = IDLE;
               end
            end
         end

         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle main memory model.
// Expectations follow the build: critical-word-first order when CACHE_FILL_CRITICAL_WORD_FIRST_EN is defined.
module tb_cache_fill_fsm;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   cache_fill_fsm_if #(.BLOCK_WORDS(8), .ADDR_WIDTH(16)) bus ();

   cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // Memory model: a request seen in cycle k returns its word in cycle k+4.
   logic        pipe_v [4] = '{default: 1'b0};
   logic [15:0] pipe_a [4] = '{default: 16'h0};
   logic        model_valid = 1'b0;
   logic [15:0] model_data  = 16'h0;
   logic        spur_valid  = 1'b0;

   function automatic logic [15:0] data_of(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   assign bus.memory_data_valid = model_valid | spur_valid;
   assign bus.memory_data       = spur_valid ? 16'hBEEF : model_data;

   always @(posedge clk) begin
      #1;
      model_valid = pipe_v[3];
      model_data  = data_of(pipe_a[3]);
      for (int i = 3; i > 0; i--) begin
         pipe_v[i] = pipe_v[i-1];
         pipe_a[i] = pipe_a[i-1];
      end
      pipe_v[0] = bus.memory_enable;
      pipe_a[0] = bus.memory_address;
   end

   function automatic logic [4:0] ctl();
      return {bus.fsm_busy, bus.memory_enable, bus.write_data_array, bus.write_tag_array, bus.fill_done};
   endfunction

   // One fill: miss driven in cycle 0, checks in cycles 0..12. Optional held spurious miss and reset abort.
   task automatic run_fill(input string name, input logic [15:0] addr, input bit hold_miss, input int abort_cycle);
      logic [15:0] base;
      logic [15:0] exp_addr;
      logic [2:0]  crit;
      logic [2:0]  ord;
      logic [4:0]  exp_ctl;
      bit          aborted;
      base = addr & 16'hFFF0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      crit = addr[3:1];
`else
      crit = 3'd0;
`endif
      @(posedge clk); #1;
      bus.miss_detected = 1'b1;
      bus.miss_address  = addr;
      #1;
      total++;
      if (ctl() !== 5'b00000) begin
         bad++;
         $display("FAIL %s c0 idle ctl got=%b want=00000", name, ctl());
      end
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         bus.miss_detected = hold_miss && (c <= 11);
         bus.miss_address  = hold_miss ? 16'h4000 : 16'h0000;
         rst = (c == abort_cycle);
         #1;
         aborted = (abort_cycle > 0) && (c > abort_cycle);
         exp_ctl = {!aborted, !aborted && c <= 8, !aborted && c >= 5,
                    !aborted && c == 12, !aborted && c == 12};
         total++;
         if (ctl() !== exp_ctl) begin
            bad++;
            $display("FAIL %s c%0d ctl got=%b want=%b", name, c, ctl(), exp_ctl);
         end
         if (exp_ctl[3]) begin
            ord      = crit + 3'(c - 1);
            exp_addr = base | {12'h000, ord, 1'b0};
            total++;
            if (bus.memory_address !== exp_addr) begin
               bad++;
               $display("FAIL %s c%0d addr got=%h want=%h", name, c, bus.memory_address, exp_addr);
            end
         end
         if (exp_ctl[2]) begin
            ord      = crit + 3'(c - 5);
            exp_addr = base | {12'h000, ord, 1'b0};
            total++;
            if (bus.word_offset !== ord || bus.fill_data !== data_of(exp_addr)) begin
               bad++;
               $display("FAIL %s c%0d write got=%0d/%h want=%0d/%h", name, c,
                        bus.word_offset, bus.fill_data, ord, data_of(exp_addr));
            end
         end
         if (aborted) begin
            total++;
            if (bus.memory_address !== 16'h0 || bus.word_offset !== 3'd0) begin
               bad++;
               $display("FAIL %s c%0d abort addr/off got=%h/%0d want=0000/0", name, c,
                        bus.memory_address, bus.word_offset);
            end
         end
      end
      $display("fill %s miss=%h base=%h abort=%0d checked", name, addr, base, abort_cycle);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.miss_detected = 1'b0;
      bus.miss_address  = 16'h0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         rst = (c < 1);
         #1;
         total++;
         if (ctl() !== 5'b00000 || bus.memory_address !== 16'h0 || bus.word_offset !== 3'd0) begin
            bad++;
            $display("FAIL reset c%0d got ctl=%b addr=%h off=%0d want 0", c, ctl(),
                     bus.memory_address, bus.word_offset);
         end
      end
      $display("reset sequence checked");
   endtask

   task automatic test_idle_valid();
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         spur_valid = (c < 3);
         #1;
         total++;
         if (ctl() !== 5'b00000 || bus.word_offset !== 3'd0) begin
            bad++;
            $display("FAIL idle_valid c%0d got ctl=%b off=%0d want 0", c, ctl(), bus.word_offset);
         end
      end
      spur_valid = 1'b0;
      $display("idle valid pulses checked");
   endtask

   task automatic test_basic_fill();
      run_fill("basic", 16'h1236, 1'b0, 0);
   endtask

   task automatic test_spurious_miss();
      run_fill("spurious", 16'h1230, 1'b1, 0);
   endtask

   task automatic test_reset_mid_fill();
      run_fill("abort", 16'h1236, 1'b0, 7);
      run_fill("after_abort", 16'h0010, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      run_fill("wrap", 16'hFFF0, 1'b0, 0);
      run_fill("b2b", 16'h2348, 1'b0, 0);
   endtask

   task automatic test_final_idle();
      @(posedge clk); #2;
      total++;
      if (ctl() !== 5'b00000) begin
         bad++;
         $display("FAIL final_idle got ctl=%b want=00000", ctl());
      end
   endtask

   initial begin
      bus.miss_detected = 1'b0;
      bus.miss_address  = 16'h0;
      test_reset();
      test_idle_valid();
      test_basic_fill();
      test_spurious_miss();
      test_reset_mid_fill();
      test_back_to_back();
      test_final_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller that sits between a direct-mapped cache and the multi-cycle main memory, directly upstream of the pipeline's instruction and data fetch path. On a cache miss it streams one full block from memory, one request per cycle. It steers each returned word into the cache data array and writes the tag on the final word. It holds the pipeline busy until the block is resident.

## Interface
Parameters:
- BLOCK_WORDS, 8: 16-bit words per cache block; power of two, 2..16.
- ADDR_WIDTH, 16: byte address width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-high.
- miss_detected  input  1  cache lookup missed this cycle.
- miss_address  input  ADDR_WIDTH  byte address of the missing access.
- memory_data_valid  input  1  main memory returns a word this cycle.
- memory_data  input  16  returned word.
- memory_enable  output  1  request strobe to main memory, read only.
- memory_address  output  ADDR_WIDTH  byte address of the current request.
- fsm_busy  output  1  fill in progress; stalls the pipeline.
- write_data_array  output  1  write fill_data into the cache at word_offset.
- word_offset  output  log2(BLOCK_WORDS)  word index within the block being written.
- fill_data  output  16  word to write; equals memory_data.
- write_tag_array  output  1  write the tag and valid bit for the block.
- fill_done  output  1  one-cycle pulse when the block is complete.

## Operation
- States: IDLE and FILL.
- IDLE behaviour:
  - When miss_detected=1 at a clock edge, latch block_base = miss_address with the low log2(BLOCK_WORDS)+1 bits cleared.
  - Clear req_cnt and recv_cnt, then go to FILL.
- FILL request side:
  - memory_enable=1 while req_cnt < BLOCK_WORDS.
  - memory_address = block_base + 2×req_order(req_cnt).
  - req_cnt increments every cycle until it saturates at BLOCK_WORDS.
- FILL receive side:
  - Each cycle with memory_data_valid=1 drives write_data_array=1, word_offset=req_order(recv_cnt) and fill_data=memory_data, then increments recv_cnt.
- Completion:
  - The valid that carries the last word (recv_cnt = BLOCK_WORDS−1) also drives write_tag_array=1 and fill_done=1 in the same cycle.
  - State returns to IDLE on the next edge.
- Address arithmetic is modulo 2^ADDR_WIDTH. The block never crosses a block boundary.
- Default ordering: req_order(i)=i.
- fsm_busy = (state==FILL).
- Boundary cases:
  - miss_detected while in FILL: ignored; no re-latch.
  - memory_data_valid in IDLE: ignored; no writes.
  - valid arriving after recv_cnt has reached BLOCK_WORDS: ignored.
  - Requests and returns overlapping in the same cycle: both are handled independently.
- Reset, including mid-fill:
  - Next state is IDLE; counters and block_base are 0.
  - All outputs are 0 in the cycle after reset is sampled.
  - No tag write occurs for the aborted block.

## Timing
- Reset values: memory_enable=0, memory_address=0, fsm_busy=0, write_data_array=0, word_offset=0, fill_data=memory_data (combinational), write_tag_array=0, fill_done=0.
- Miss sampled at edge E0. fsm_busy is high from E0 until the edge after the final write.
- Requests are issued in the BLOCK_WORDS consecutive cycles after E0, with no gaps.
- With 4-cycle memory and BLOCK_WORDS=8:
  - requests in cycles 1–8;
  - data writes in cycles 5–12;
  - tag write and fill_done in cycle 12;
  - IDLE from cycle 13.
  - Total fill latency is 12 cycles after the miss.
- A new miss_detected in the IDLE cycle right after completion starts a new fill with no bubble.
- Outputs are combinational from state and counters. There are no registered output stages.

## Configuration
- Macro CACHE_FILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - req_order(i) = (crit + i) mod BLOCK_WORDS, where crit = miss_address[log2(BLOCK_WORDS):1] latched at the miss.
  - Requests and word_offset both follow this wrapped order, so the missing word arrives first.
- Undefined: req_order(i)=i. The crit register is not synthesized.
- Port list is identical in both builds.

## Test plan
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then no miss.
  - Required: all outputs 0, fsm_busy 0, no memory_enable.
- Basic fill (macro off, 4-cycle memory model):
  - Stimulus: miss_address=0x1236.
  - Required: memory_address 0x1230,0x1232,…,0x123E in cycles 1–8; word_offset 0..7 in cycles 5–12; write_tag_array and fill_done in cycle 12 only.
- Critical word first (macro on):
  - Stimulus: miss_address=0x1236.
  - Required: addresses 0x1236,0x1238,0x123A,0x123C,0x123E,0x1230,0x1232,0x1234; word_offsets 3,4,5,6,7,0,1,2.
- Spurious inputs:
  - Stimulus: memory_data_valid pulses in IDLE; miss_detected=1 with miss_address=0x4000 held during a fill at 0x1230.
  - Required: no writes in IDLE; block_base stays 0x1230.
- Reset mid-fill:
  - Stimulus: assert rst in cycle 7 of a fill.
  - Required: IDLE next cycle, write_tag_array never asserted; a following miss at 0x0010 fetches 0x0010..0x001E cleanly.
- Back-to-back misses and wrap:
  - Stimulus: miss at 0xFFF0, then a miss asserted in the first IDLE cycle after completion.
  - Required: addresses 0xFFF0..0xFFFE, no overflow into 0x0000; second fill begins requests the cycle after it is sampled.
